// File: rtl/line_mem_responder.sv
// line_mem_responder: line-granular main-memory stand-in for the cache
// controller's 256-bit line port. Serves one read or write-back at a time,
// completing it with a single-cycle mem_ready pulse after a fixed latency.
module line_mem_responder #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 256,
  parameter int IDX_W  = 8,
  parameter int RD_LAT = 4,
  parameter int WR_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wr,
  input  logic              mem_rw,
  input  logic              mem_valid,
  output logic [LINE_W-1:0] mem_rd,
  output logic              mem_ready,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  // The counter holds LAT-1 at accept and reaches zero on the last WAIT cycle.
  localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 1);
  localparam int         DEPTH   = 1 << IDX_W;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic                rw_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [7:0]          cnt_q;
  logic [LINE_W-1:0]   mem_rd_q;
  logic [15:0]         rd_count_q;
  logic [15:0]         wr_count_q;
  logic [LINE_W-1:0]   store [DEPTH];

  // Offset bits and aliased upper address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[2:0], mem_addr[ADDR_W-1:3+IDX_W]};

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    mem_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (mem_valid) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_RESP;
      end
      S_RESP: begin
        mem_ready = 1'b1;
        state_d   = S_RELEASE;
      end
      S_RELEASE: begin
        // A level mem_valid still held high must not re-issue the request.
        if (!mem_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request capture, latency counter, read data and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= 8'd0;
      mem_rd_q   <= '0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (mem_valid) begin
            idx_q   <= mem_addr[3 +: IDX_W];
            rw_q    <= mem_rw;
            wdata_q <= mem_wr;
            cnt_q   <= mem_rw ? WR_LOAD : RD_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else if (!rw_q) begin
            // Registered on entry to RESP so data and mem_ready align.
            mem_rd_q <= store[idx_q];
          end
        end
        S_RESP: begin
          if (rw_q) begin
            if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
          end else begin
            if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write-back commit at the end of the RESP cycle; a reset in that cycle
  // drops the write.
  always_ff @(posedge clk) begin
    // NOTE: the backing store has no reset; its contents survive rst, and
    // leaving it out keeps the array mappable onto block RAM.
    if (!rst && state_q == S_RESP && rw_q) begin
      store[idx_q] <= wdata_q;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder: directed vector table, hand-written
// multi-cycle corner sequences, and randomized traffic against a simple
// array-based reference model.
module tb_line_mem_responder;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 256;
  localparam int IDX_W  = 8;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;
  localparam int BUDGET = 300;

  localparam logic [LINE_W-1:0] PRE0 =
    256'h0A0A0B0B_ABCDEF12_66665555_BDC14444_12345678_ADADBABA_58850990_3FBABAF1;
  localparam logic [LINE_W-1:0] DEAD = {8{32'hDEADBEEF}};
  localparam logic [LINE_W-1:0] COFE = {8{32'h0C0FFEE0}};

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wr;
  logic              mem_rw;
  logic              mem_valid;
  logic [LINE_W-1:0] mem_rd;
  logic              mem_ready;
  logic              busy;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  line_mem_responder #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .IDX_W(IDX_W),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_rw(mem_rw), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .busy(busy), .rd_count(rd_count),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain line array, saturating counters, last read data.
  logic [LINE_W-1:0] model_store [1 << IDX_W];
  logic [15:0]       model_rdc;
  logic [15:0]       model_wrc;
  logic [LINE_W-1:0] model_last_rd;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] exp_rd;
    logic [15:0]       exp_rdc;
    logic [15:0]       exp_wrc;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic int lat_of(input logic rw);
    return rw ? WR_LAT : RD_LAT;
  endfunction

  // Issue one request from IDLE and return its measured latency, the read
  // data seen with mem_ready, and mem_ready one cycle later. With mutate set,
  // the address and data inputs are scrambled right after the accept edge.
  task automatic run_req(input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wd, input bit mutate,
                         output int lat, output logic [LINE_W-1:0] rd,
                         output logic ready_after);
    mem_addr  = addr;
    mem_wr    = wd;
    mem_rw    = rw;
    mem_valid = 1'b1;
    tick();
    if (mutate) begin
      mem_addr = 28'h20;
      mem_wr   = ~wd;
    end
    lat = 0;
    while (lat < BUDGET) begin
      tick();
      lat++;
      if (mem_ready) break;
    end
    rd = mem_rd;
    mem_valid = 1'b0;
    tick();
    ready_after = mem_ready;
    tick();
  endtask

  // Run a request and compare everything against the reference model.
  task automatic model_req(input string tag, input logic rw,
                           input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wd, input bit mutate);
    int                lat;
    logic [LINE_W-1:0] rd;
    logic              ra;
    logic [IDX_W-1:0]  idx;
    idx = addr[3 +: IDX_W];
    run_req(rw, addr, wd, mutate, lat, rd, ra);
    if (rw) begin
      model_store[idx] = wd;
      model_wrc = sat_inc(model_wrc);
    end else begin
      model_last_rd = model_store[idx];
      model_rdc = sat_inc(model_rdc);
    end
    check({tag, " latency"}, LINE_W'(lat), LINE_W'(lat_of(rw)));
    check({tag, " mem_rd"}, rd, model_last_rd);
    check({tag, " single pulse"}, LINE_W'(ra), '0);
    check({tag, " busy idle"}, LINE_W'(busy), '0);
    check({tag, " rd_count"}, LINE_W'(rd_count), LINE_W'(model_rdc));
    check({tag, " wr_count"}, LINE_W'(wr_count), LINE_W'(model_wrc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int                lat;
    int                pulses;
    logic [LINE_W-1:0] rd;
    logic              ra;
    logic [LINE_W-1:0] v;

    rst = 1'b1;
    mem_addr = '0;
    mem_wr = '0;
    mem_rw = 1'b0;
    mem_valid = 1'b0;

    // Backdoor preload of the backing store, mirrored into the model.
    for (int i = 0; i < (1 << IDX_W); i++) begin
      v = rand_line();
      if (i == 0) v = PRE0;
      dut.store[i] = v;
      model_store[i] = v;
    end
    model_rdc = 16'd0;
    model_wrc = 16'd0;
    model_last_rd = '0;

    tick();
    tick();
    rst = 1'b0;
    check("reset mem_ready", LINE_W'(mem_ready), '0);
    check("reset busy", LINE_W'(busy), '0);
    check("reset mem_rd", mem_rd, '0);
    check("reset rd_count", LINE_W'(rd_count), '0);
    check("reset wr_count", LINE_W'(wr_count), '0);

    // Directed vectors: read, write, same-line read with offset bits set,
    // aliased write over idx 0, read back of idx 0.
    vecs[0] = '{1'b0, 28'h000, '0,   PRE0, 16'd1, 16'd0};
    vecs[1] = '{1'b1, 28'h008, DEAD, PRE0, 16'd1, 16'd1};
    vecs[2] = '{1'b0, 28'h00F, '0,   DEAD, 16'd2, 16'd1};
    vecs[3] = '{1'b1, 28'h800, COFE, DEAD, 16'd2, 16'd2};
    vecs[4] = '{1'b0, 28'h000, '0,   COFE, 16'd3, 16'd2};
    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0, lat, rd, ra);
      if (vecs[i].rw) begin
        model_store[vecs[i].addr[3 +: IDX_W]] = vecs[i].wdata;
        model_wrc = sat_inc(model_wrc);
      end else begin
        model_last_rd = model_store[vecs[i].addr[3 +: IDX_W]];
        model_rdc = sat_inc(model_rdc);
      end
      check($sformatf("vec%0d latency", i), LINE_W'(lat),
            LINE_W'(vecs[i].rw ? WR_LAT : RD_LAT));
      check($sformatf("vec%0d mem_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d pulse", i), LINE_W'(ra), '0);
      check($sformatf("vec%0d rd_count", i), LINE_W'(rd_count),
            LINE_W'(vecs[i].exp_rdc));
      check($sformatf("vec%0d wr_count", i), LINE_W'(wr_count),
            LINE_W'(vecs[i].exp_wrc));
    end

    // Held mem_valid: one pulse only, then a re-arm after one low cycle.
    mem_addr = 28'h028;
    mem_rw = 1'b0;
    mem_valid = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_ready) pulses++;
    end
    model_last_rd = model_store[5];
    model_rdc = sat_inc(model_rdc);
    check("hold pulses", LINE_W'(pulses), LINE_W'(1));
    check("hold mem_rd", mem_rd, model_last_rd);
    check("hold rd_count", LINE_W'(rd_count), LINE_W'(model_rdc));
    check("hold busy", LINE_W'(busy), LINE_W'(1));
    mem_valid = 1'b0;
    tick();
    check("hold release busy", LINE_W'(busy), '0);
    model_req("rearm", 1'b0, 28'h028, '0, 1'b0);

    // Inputs changed during WAIT of a write to idx 2 are ignored.
    v = rand_line();
    model_req("mutate", 1'b1, 28'h010, v, 1'b1);
    model_req("mutate rd2", 1'b0, 28'h010, '0, 1'b0);
    model_req("mutate rd4", 1'b0, 28'h020, '0, 1'b0);

    // Reset in the second WAIT cycle of a write to idx 3.
    mem_addr = 28'h018;
    mem_wr = ~model_store[3];
    mem_rw = 1'b1;
    mem_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    mem_valid = 1'b0;
    tick();
    rst = 1'b0;
    model_rdc = 16'd0;
    model_wrc = 16'd0;
    model_last_rd = '0;
    check("abort busy", LINE_W'(busy), '0);
    check("abort mem_ready", LINE_W'(mem_ready), '0);
    check("abort wr_count", LINE_W'(wr_count), '0);
    check("abort mem_rd", mem_rd, '0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_ready) pulses++;
    end
    check("abort no pulse", LINE_W'(pulses), '0);
    model_req("abort rd3", 1'b0, 28'h018, '0, 1'b0);

    // Counter saturation.
    dut.rd_count_q = 16'hFFFF;
    dut.wr_count_q = 16'hFFFE;
    model_rdc = 16'hFFFF;
    model_wrc = 16'hFFFE;
    model_req("sat rd", 1'b0, 28'h030, '0, 1'b0);
    model_req("sat wr1", 1'b1, 28'h038, rand_line(), 1'b0);
    model_req("sat wr2", 1'b1, 28'h040, rand_line(), 1'b0);

    // Randomized traffic over a small index set with random alias/offset bits.
    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      logic              rw;
      a = ADDR_W'($urandom);
      a[3 +: IDX_W] = IDX_W'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      model_req($sformatf("rnd%0d", t), rw, a, rand_line(), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the cache controller's 256-bit line interface (mem_addr/mem_wr/mem_rw/mem_valid in, mem_rd/mem_ready out).
- Holds a line-granular backing store and serves one read or write-back request at a time, after a programmable latency.
- Used as the main-memory stand-in beneath cache_controller in simulation and in FPGA bring-up builds.

Parameters:
ADDR_W, 28, width of mem_addr (32-bit word address)
LINE_W, 256, line width in bits (8 words)
IDX_W, 8, log2 of stored lines; line index = mem_addr[3 +: IDX_W]
RD_LAT, 4, cycles from request accept to mem_ready for reads (legal range 1..255)
WR_LAT, 4, cycles from request accept to mem_ready for writes (legal range 1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
mem_addr  in  ADDR_W  line word address; bits [2:0] ignored
mem_wr  in  LINE_W  write-back line data
mem_rw  in  1  1 = write, 0 = read
mem_valid  in  1  request valid, level
mem_rd  out  LINE_W  read line data
mem_ready  out  1  one-cycle completion pulse
busy  out  1  high from accept until return to IDLE
rd_count  out  16  completed reads, saturating
wr_count  out  16  completed writes, saturating

Behaviour:
- Reset (rst high at a clock edge): state=IDLE; mem_ready=0; mem_rd=0; busy=0; rd_count=0; wr_count=0; latency counter=0. The storage array is not cleared. Reset mid-request abandons the request, and a pending write is not committed.
- States: IDLE, WAIT, RESP, RELEASE.
- IDLE: if mem_valid=1, accept the request.
  - Capture idx=mem_addr[3 +: IDX_W], mem_rw and mem_wr.
  - Load counter with RD_LAT-1 (read) or WAIT_LAT-1... specifically WR_LAT-1 (write).
  - Set busy=1 and go to WAIT.
  - Address bits above the index alias; no error is flagged.
- WAIT: decrement the counter each cycle. At counter==0, go to RESP. Input changes during WAIT are ignored because captured values are used.
- RESP (exactly one cycle): mem_ready=1.
  - Read: mem_rd = store[idx], registered so it is valid in the same cycle as mem_ready. rd_count increments unless it is 0xFFFF.
  - Write: store[idx] = captured mem_wr, committed at the end of the RESP cycle. mem_rd holds its previous value. wr_count increments unless it is 0xFFFF.
  - Go to RELEASE.
- RELEASE: mem_ready=0, busy=1. Stay until mem_valid=0 is sampled, then go to IDLE with busy=0. This prevents a held mem_valid from re-issuing the same request.
- Total latency: mem_ready is high exactly LAT cycles after the accept edge (accept at edge N, mem_ready high during cycle N+LAT).
- Minimum request spacing: accept, LAT cycles, RESP, at least 1 cycle of mem_valid low, then the next accept.
- mem_rd is stable outside RESP cycles and changes only on read completion or reset.
- Read-after-write to the same idx returns the new data, because the write commits before the RESP→RELEASE transition completes.
- Width rules:
  - Counters saturate and do not wrap.
  - The latency counter is 8 bits.
  - RD_LAT=1 means accept at N and mem_ready in cycle N+1 (WAIT lasts one cycle).

Test Plan:
- Reset, then read idx 0 (mem_addr=0x0) → mem_ready high exactly 4 cycles after accept. mem_rd equals the preloaded store[0] (bench backdoor preload 0x0A0A0B0B_ABCDEF12_66665555_BDC14444_12345678_ADADBABA_58850990_3FBABAF1). rd_count=1.
- Write mem_addr=0x8, mem_wr={8{32'hDEADBEEF}}, mem_rw=1 → mem_ready after 4 cycles, wr_count=1. A following read of mem_addr=0xF (same line; low bits ignored) returns {8{32'hDEADBEEF}}.
- Hold mem_valid=1 for 20 cycles on a single read → exactly one mem_ready pulse and rd_count=1. Deassert for 1 cycle, reassert → second pulse 4 cycles after the new accept.
- Change mem_addr and mem_wr during WAIT of a write to 0x10 → the data captured at accept is written to idx 2. The new values are ignored.
- Assert rst in the second WAIT cycle of a write to 0x18 → no mem_ready, idx 3 unchanged, wr_count=0, busy=0 next cycle.
- Aliasing and saturation: write mem_addr=0x800 with IDX_W=8 → overwrites idx 0. Force rd_count to 0xFFFF, do one read → rd_count stays 0xFFFF.
